// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit, one shift-add or
// restoring shift-subtract step per cycle, with divide fast paths.
module muldiv_seq #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall_ex,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);
  localparam int CW = $clog2(ITER + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] b_mag;
  logic [2*XLEN-1:0] acc;
  logic [2:0] f3;
  logic [4:0] rd_q;
  logic neg_p, neg_a;
  logic idle_like, sa, sb, an, bn, div0, ovf;
  logic [XLEN-1:0] a_abs, b_abs, fast_res, q_f, r_f, fin;
  logic [XLEN:0] msum;
  logic [XLEN+1:0] dd;
  logic [2*XLEN-1:0] mul_n, div_n, nxt, pf;
  assign idle_like = state == IDLE || state == DONE;
  assign busy      = state == MUL || state == DIV;
  assign done      = state == DONE;
  assign stall_ex  = busy | (start & rst_n & idle_like & ~flush);
  assign sa    = funct3 == 3'b001 || funct3 == 3'b010 || (funct3[2] && !funct3[0]);
  assign sb    = funct3 == 3'b001 || (funct3[2] && !funct3[0]);
  assign an    = sa & op_a[XLEN-1];
  assign bn    = sb & op_b[XLEN-1];
  assign a_abs = an ? -op_a : op_a;
  assign b_abs = bn ? -op_b : op_b;
  assign div0  = funct3[2] && op_b == '0;
  assign ovf   = funct3[2] && !funct3[0] && op_a == {1'b1, {(XLEN-1){1'b0}}} && op_b == '1;
  // overflow case: quotient equals the dividend, remainder is zero
  assign fast_res = div0 ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
  // low half of acc holds multiplier / dividend-quotient, high half the partial product / remainder
  assign msum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_n = {msum, acc[XLEN-1:1]};
  assign dd    = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, b_mag};
  assign div_n = !dd[XLEN+1] ? {dd[XLEN-1:0], acc[XLEN-2:0], 1'b1} : {acc[2*XLEN-2:0], 1'b0};
  assign nxt   = state == MUL ? mul_n : div_n;
  assign pf    = neg_p ? -nxt : nxt;
  assign q_f   = neg_p ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
  assign r_f   = neg_a ? -nxt[2*XLEN-1:XLEN] : nxt[2*XLEN-1:XLEN];
  assign fin   = state == MUL ? (f3 == 3'b000 ? pf[XLEN-1:0] : pf[2*XLEN-1:XLEN])
                              : (f3[1] ? r_f : q_f);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      b_mag  <= '0;
      acc    <= '0;
      f3     <= '0;
      rd_q   <= '0;
      neg_p  <= 1'b0;
      neg_a  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (idle_like && start) begin
      f3    <= funct3;
      rd_q  <= rd_in;
      cnt   <= '0;
      b_mag <= b_abs;
      acc   <= {{XLEN{1'b0}}, a_abs};
      neg_p <= an ^ bn;
      neg_a <= an;
      if (div0 || ovf) begin
        state  <= DONE;
        result <= fast_res;
        rd_out <= rd_in;
      end else begin
        state <= funct3[2] ? DIV : MUL;
      end
    end else if (busy) begin
      acc <= nxt;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(ITER - 1)) begin
        state  <= DONE;
        result <= fin;
        rd_out <= rd_q;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL provide parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL provide parameter ITER, default 32, iteration cycles per long operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  EX stage holds an RV32M instruction; sampled only in IDLE or DONE.
REQ-006 funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  32  forwarded source 1 (post-forwarding-mux value).
REQ-008 op_b  input  32  forwarded source 2 (post-forwarding-mux value).
REQ-009 rd_in  input  5  destination register of the operation.
REQ-010 flush  input  1  branch-taken kill of the EX instruction.
REQ-011 stall_ex  output  1  freeze PC/IF/ID/EX pipeline registers.
REQ-012 done  output  1  one-cycle pulse: result and rd_out valid.
REQ-013 result  output  32  operation result.
REQ-014 rd_out  output  5  destination register captured at start.
REQ-015 busy  output  1  state is MUL or DIV.

Function
REQ-016 SHALL implement four states (IDLE, MUL, DIV, DONE), encoded in a single registered state variable.
REQ-017 IDLE/DONE with start=1, flush=0: capture op_a/op_b magnitudes, sign flags, funct3, rd_in; clear counter; go MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-018 Divide fast paths SHALL go directly to DONE on the next edge: op_b=0 -> DIV/DIVU result 0xFFFFFFFF, REM/REMU result op_a; DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF -> DIV 0x80000000, REM 0.
REQ-019 MUL: one shift-add step per cycle on unsigned magnitudes into a 64-bit product; after ITER steps go DONE.
REQ-020 DIV: one restoring shift-subtract step per cycle, 32-bit quotient and remainder; after ITER steps go DONE.
REQ-021 Signedness: MULH/DIV/REM both operands signed; MULHSU op_a signed, op_b unsigned; MULHU/DIVU/REMU/MUL unsigned magnitude (MUL low word is sign-independent).
REQ-022 Result sign: product negated iff operand signs differ (signed operands only); quotient negated iff signs differ; remainder takes dividend sign.
REQ-023 Result select: MUL low 32 bits; MULH/MULHSU/MULHU high 32 bits; DIV/DIVU quotient; REM/REMU remainder.
REQ-024 DONE lasts exactly one cycle; done=1, result and rd_out valid; without a new start, next state IDLE.
REQ-025 Long-op latency: start sampled at edge N, done=1 during cycle N+ITER+1 (33 cycles after acceptance for ITER=32); fast path: done during cycle N+1.
REQ-026 stall_ex = busy OR (start AND state in {IDLE, DONE} AND NOT flush); stall_ex=0 in DONE without start, so the pipeline advances exactly once per operation.
REQ-027 start in DONE SHALL be accepted as a new operation (back-to-back), while done still pulses for the completing one.
REQ-028 start in MUL/DIV SHALL be ignored.
REQ-029 flush in any state: next state IDLE, no done pulse, captured operands discarded; flush has priority over start.
REQ-030 result and rd_out SHALL hold their last value outside DONE; they are not cleared by flush.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, counter 0, done=0, busy=0, stall_ex=0, result=0, rd_out=0, all internal operand/product registers 0.
REQ-032 Deassertion of rst_n mid-operation SHALL leave the block in IDLE; the interrupted operation never completes.

Verification
REQ-033 MUL op_a=7, op_b=-3 (0xFFFFFFFD), rd_in=5 -> done at 33rd cycle after acceptance, result 0xFFFFFFEB, rd_out=5, stall_ex high for 33 cycles then low.
REQ-034 MULH 0x80000000 x 0x80000000 -> result 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE.
REQ-035 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
REQ-036 DIV x/0 -> 0xFFFFFFFF and REM 13/0 -> 13, done one cycle after start; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-037 flush asserted 10 cycles into a DIV -> IDLE next edge, no done, stall_ex low; start asserted with flush -> not accepted.
REQ-038 rst_n pulsed low mid-MUL -> all outputs 0 immediately; back-to-back start in DONE -> second done exactly 33 cycles after the first.
